hazard_forward_unit: RTL and testbench

//  Pipeline hazard controller. Generates the execute-stage forwarding selects
//  (forward_one/two_execute) consumed by the ALU input mux, plus decode

---
 rtl/hazard_forward_unit.sv | 167 ++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: execute/decode forwarding selects, load-use,
// branch and HI/LO stalls, execute flush, multicycle mult/div busy tracking.
// Ports:
//   in : clk, reset, decode/execute/memory/writeback register ids and flags
//   out: forward_one/two_execute (3b), forward_A/B_decode,
//        stall_fetch, stall_decode, flush_execute_register, mult_div_busy
// Config: HAZARD_PERF_COUNTERS_EN adds stall_cycles / md_stall_cycles.
module hazard_forward_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 34
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_decode,
  input  logic [4:0] rt_decode,
  input  logic       branch_decode,
  input  logic [4:0] rs_execute,
  input  logic [4:0] rt_execute,
  input  logic [4:0] write_reg_execute,
  input  logic       reg_write_execute,
  input  logic       mem_to_reg_execute,
  input  logic       hi_lo_read_execute,
  input  logic       mult_div_start_execute,
  input  logic       is_div_execute,
  input  logic [4:0] write_reg_memory,
  input  logic       reg_write_memory,
  input  logic       mem_to_reg_memory,
  input  logic       hi_lo_write_memory,
  input  logic [4:0] write_reg_writeback,
  input  logic       reg_write_writeback,
  input  logic       hi_lo_write_writeback,
  output logic [2:0] forward_one_execute,
  output logic [2:0] forward_two_execute,
  output logic       forward_A_decode,
  output logic       forward_B_decode,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       flush_execute_register,
  output logic       mult_div_busy
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  localparam logic [2:0] FW_REG   = 3'b000;
  localparam logic [2:0] FW_WB    = 3'b001;
  localparam logic [2:0] FW_MEM   = 3'b010;
  localparam logic [2:0] FW_HL_WB = 3'b011;
  localparam logic [2:0] FW_HL_MEM = 3'b100;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

  logic [5:0] r_md_count;

  // Register 0 is hardwired, so it never creates a dependency.
  logic w_a_mem, w_a_wb, w_b_mem, w_b_wb;
  logic w_rs_d_mem, w_rt_d_mem;
  logic w_rs_d_ex, w_rt_d_ex;
  logic w_lw_stall, w_br_stall, w_md_stall;
  logic w_any_stall, w_busy;

  assign w_a_mem = (rs_execute != 5'd0) && reg_write_memory
                   && (write_reg_memory == rs_execute);
  assign w_a_wb  = (rs_execute != 5'd0) && reg_write_writeback
                   && (write_reg_writeback == rs_execute);
  assign w_b_mem = (rt_execute != 5'd0) && reg_write_memory
                   && (write_reg_memory == rt_execute);
  assign w_b_wb  = (rt_execute != 5'd0) && reg_write_writeback
                   && (write_reg_writeback == rt_execute);

  assign w_rs_d_mem = (rs_decode != 5'd0)
                      && (write_reg_memory == rs_decode);
  assign w_rt_d_mem = (rt_decode != 5'd0)
                      && (write_reg_memory == rt_decode);
  assign w_rs_d_ex  = (rs_decode != 5'd0)
                      && (write_reg_execute == rs_decode);
  assign w_rt_d_ex  = (rt_decode != 5'd0)
                      && (write_reg_execute == rt_decode);

  assign w_busy = (r_md_count != 6'd0);

  assign w_lw_stall = mem_to_reg_execute && (w_rs_d_ex || w_rt_d_ex);
  assign w_br_stall = branch_decode
    && ((reg_write_execute && (w_rs_d_ex || w_rt_d_ex))
     || (mem_to_reg_memory && (w_rs_d_mem || w_rt_d_mem)));
  assign w_md_stall = w_busy
    && (hi_lo_read_execute || mult_div_start_execute);

  assign w_any_stall = !reset && (w_lw_stall || w_br_stall || w_md_stall);

  // HI/LO reads override GPR forwarding: LO on the A path, HI on B.
  always_comb begin
    forward_one_execute = FW_REG;
    if (reset) begin
      forward_one_execute = FW_REG;
    end else if (hi_lo_read_execute) begin
      if (hi_lo_write_memory)
        forward_one_execute = FW_HL_MEM;
      else if (hi_lo_write_writeback)
        forward_one_execute = FW_HL_WB;
    end else if (w_a_mem) begin
      forward_one_execute = FW_MEM;
    end else if (w_a_wb) begin
      forward_one_execute = FW_WB;
    end
  end

  always_comb begin
    forward_two_execute = FW_REG;
    if (reset) begin
      forward_two_execute = FW_REG;
    end else if (hi_lo_read_execute) begin
      if (hi_lo_write_memory)
        forward_two_execute = FW_HL_MEM;
      else if (hi_lo_write_writeback)
        forward_two_execute = FW_HL_WB;
    end else if (w_b_mem) begin
      forward_two_execute = FW_MEM;
    end else if (w_b_wb) begin
      forward_two_execute = FW_WB;
    end
  end

  assign forward_A_decode = !reset && reg_write_memory && w_rs_d_mem;
  assign forward_B_decode = !reset && reg_write_memory && w_rt_d_mem;

  assign stall_fetch            = w_any_stall;
  assign stall_decode           = w_any_stall;
  assign flush_execute_register = reset || w_any_stall;
  assign mult_div_busy          = w_busy;

  // A start seen while busy is stalled upstream and re-presented, so it
  // is picked up on the first cycle the counter reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_count <= 6'd0;
    end else if (mult_div_start_execute && !w_busy && !w_md_stall) begin
      r_md_count <= is_div_execute ? DIV_LOAD : MULT_LOAD;
    end else if (w_busy) begin
      r_md_count <= r_md_count - 6'd1;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_md_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles    <= 32'd0;
      r_md_stall_cycles <= 32'd0;
    end else begin
      if (w_any_stall && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_md_stall && (r_md_stall_cycles != 32'hFFFF_FFFF))
        r_md_stall_cycles <= r_md_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign md_stall_cycles = r_md_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed cases then random
// traffic, checked against a cycle-numbered behavioural model.
module tb_hazard_forward_unit;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs_decode, rt_decode, rs_execute, rt_execute;
  logic [4:0] write_reg_execute, write_reg_memory, write_reg_writeback;
  logic       branch_decode, reg_write_execute, mem_to_reg_execute;
  logic       hi_lo_read_execute, mult_div_start_execute, is_div_execute;
  logic       reg_write_memory, mem_to_reg_memory, hi_lo_write_memory;
  logic       reg_write_writeback, hi_lo_write_writeback;
  logic [2:0] forward_one_execute, forward_two_execute;
  logic       forward_A_decode, forward_B_decode;
  logic       stall_fetch, stall_decode, flush_execute_register;
  logic       mult_div_busy;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  hazard_forward_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_decode(rs_decode), .rt_decode(rt_decode),
    .branch_decode(branch_decode),
    .rs_execute(rs_execute), .rt_execute(rt_execute),
    .write_reg_execute(write_reg_execute),
    .reg_write_execute(reg_write_execute),
    .mem_to_reg_execute(mem_to_reg_execute),
    .hi_lo_read_execute(hi_lo_read_execute),
    .mult_div_start_execute(mult_div_start_execute),
    .is_div_execute(is_div_execute),
    .write_reg_memory(write_reg_memory),
    .reg_write_memory(reg_write_memory),
    .mem_to_reg_memory(mem_to_reg_memory),
    .hi_lo_write_memory(hi_lo_write_memory),
    .write_reg_writeback(write_reg_writeback),
    .reg_write_writeback(reg_write_writeback),
    .hi_lo_write_writeback(hi_lo_write_writeback),
    .forward_one_execute(forward_one_execute),
    .forward_two_execute(forward_two_execute),
    .forward_A_decode(forward_A_decode),
    .forward_B_decode(forward_B_decode),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_execute_register(flush_execute_register),
    .mult_div_busy(mult_div_busy)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles)
`endif
  );

  typedef struct {
    bit       rst;
    bit [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_wb;
    bit       br_d, rw_e, m2r_e, hlr_e, st_e, div_e;
    bit       rw_m, m2r_m, hlw_m, rw_wb, hlw_wb;
  } stim_t;

  typedef struct packed {
    logic [2:0]  f1;
    logic [2:0]  f2;
    logic        fa, fb, sf, sd, fl, busy;
    logic [31:0] n_st;
    logic [31:0] n_md;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  // Model state: busy covers every cycle number below busy_until.
  stim_t cur;
  int cyc = 0;
  int busy_until = 0;
  bit last_st = 0, last_md = 0;
  int unsigned cnt_st = 0, cnt_md = 0;

  function automatic bit hit(bit [4:0] dst, bit [4:0] src);
    return (src != 0) && (dst == src);
  endfunction

  function automatic logic [2:0] gpr_sel(stim_t s, bit [4:0] src);
    if (s.rw_m && hit(s.wr_m, src)) return 3'd2;
    if (s.rw_wb && hit(s.wr_wb, src)) return 3'd1;
    return 3'd0;
  endfunction

  function automatic exp_t model(stim_t s, bit busy);
    exp_t e;
    bit lw, br, md, any;
    logic [2:0] hl;
    e = '0;
    e.n_st = cnt_st;
    e.n_md = cnt_md;
    if (s.rst) begin
      e.fl = 1'b1;
      return e;
    end
    hl = s.hlw_m ? 3'd4 : (s.hlw_wb ? 3'd3 : 3'd0);
    e.f1 = s.hlr_e ? hl : gpr_sel(s, s.rs_e);
    e.f2 = s.hlr_e ? hl : gpr_sel(s, s.rt_e);
    e.fa = s.rw_m && hit(s.wr_m, s.rs_d);
    e.fb = s.rw_m && hit(s.wr_m, s.rt_d);
    lw = s.m2r_e && (hit(s.wr_e, s.rs_d) || hit(s.wr_e, s.rt_d));
    br = s.br_d && (
         (s.rw_e && (hit(s.wr_e, s.rs_d) || hit(s.wr_e, s.rt_d)))
      || (s.m2r_m && (hit(s.wr_m, s.rs_d) || hit(s.wr_m, s.rt_d))));
    md = busy && (s.hlr_e || s.st_e);
    any = lw || br || md;
    e.sf = any;
    e.sd = any;
    e.fl = any;
    e.busy = busy;
    return e;
  endfunction

  task automatic apply(stim_t s);
    reset = s.rst;
    rs_decode = s.rs_d; rt_decode = s.rt_d; branch_decode = s.br_d;
    rs_execute = s.rs_e; rt_execute = s.rt_e;
    write_reg_execute = s.wr_e; reg_write_execute = s.rw_e;
    mem_to_reg_execute = s.m2r_e; hi_lo_read_execute = s.hlr_e;
    mult_div_start_execute = s.st_e; is_div_execute = s.div_e;
    write_reg_memory = s.wr_m; reg_write_memory = s.rw_m;
    mem_to_reg_memory = s.m2r_m; hi_lo_write_memory = s.hlw_m;
    write_reg_writeback = s.wr_wb; reg_write_writeback = s.rw_wb;
    hi_lo_write_writeback = s.hlw_wb;
  endtask

  task automatic step(stim_t s);
    bit was_busy;
    exp_t e;
    @(posedge clk);
    was_busy = cyc < busy_until;
    cyc++;
    if (cur.rst) begin
      busy_until = 0;
      cnt_st = 0;
      cnt_md = 0;
    end else begin
      if (cur.st_e && !was_busy)
        busy_until = cyc + (cur.div_e ? DIV_N : MULT_N);
      if (last_st && cnt_st != 32'hFFFF_FFFF) cnt_st++;
      if (last_md && cnt_md != 32'hFFFF_FFFF) cnt_md++;
    end
    #1;
    cur = s;
    apply(s);
    if (s.rst) begin
      busy_until = 0;
      cnt_st = 0;
      cnt_md = 0;
    end
    e = model(s, cyc < busy_until);
    last_st = e.sf;
    last_md = e.busy && !s.rst && (s.hlr_e || s.st_e);
    q.push_back(e);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t",
                  nm, act, exp, $time);
  endtask

  // Monitor: every negedge the DUT presents a settled response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd_exec", {58'd0, forward_one_execute, forward_two_execute},
            {58'd0, e.f1, e.f2});
        chk("fwd_dec", {62'd0, forward_A_decode, forward_B_decode},
            {62'd0, e.fa, e.fb});
        chk("stall", {60'd0, stall_fetch, stall_decode,
                      flush_execute_register, mult_div_busy},
            {60'd0, e.sf, e.sd, e.fl, e.busy});
`ifdef HAZARD_PERF_COUNTERS_EN
        chk("perf", {stall_cycles, md_stall_cycles}, {e.n_st, e.n_md});
`endif
      end
    end
  end

  function automatic stim_t rnd();
    stim_t s;
    s = '{default: 0};
    s.rst = ($urandom_range(0, 99) == 0);
    s.rs_d = 5'($urandom_range(0, 3));
    s.rt_d = 5'($urandom_range(0, 3));
    s.rs_e = 5'($urandom_range(0, 3));
    s.rt_e = 5'($urandom_range(0, 3));
    s.wr_e = 5'($urandom_range(0, 3));
    s.wr_m = 5'($urandom_range(0, 3));
    s.wr_wb = 5'($urandom_range(0, 3));
    s.br_d = $urandom_range(0, 3) == 0;
    s.rw_e = $urandom_range(0, 1) == 0;
    s.m2r_e = $urandom_range(0, 3) == 0;
    s.hlr_e = $urandom_range(0, 3) == 0;
    s.st_e = $urandom_range(0, 5) == 0;
    s.div_e = $urandom_range(0, 3) == 0;
    s.rw_m = $urandom_range(0, 1) == 0;
    s.m2r_m = $urandom_range(0, 3) == 0;
    s.hlw_m = $urandom_range(0, 3) == 0;
    s.rw_wb = $urandom_range(0, 1) == 0;
    s.hlw_wb = $urandom_range(0, 3) == 0;
    return s;
  endfunction

  initial begin
    stim_t z, s;
    z = '{default: 0};
    cur = z;
    cur.rst = 1;
    apply(cur);
    s = z; s.rst = 1;
    step(s); step(s);
    step(z);
    // MEM beats WB on the same source register.
    s = z; s.rs_e = 5; s.rw_m = 1; s.wr_m = 5; s.rw_wb = 1; s.wr_wb = 5;
    step(s);
    // Register 0 never forwards.
    s = z; s.rt_e = 0; s.rw_m = 1; s.wr_m = 0; s.rw_wb = 1; s.wr_wb = 0;
    step(s);
    // Load-use for one cycle.
    s = z; s.m2r_e = 1; s.wr_e = 8; s.rt_d = 8;
    step(s); step(z);
    // HI/LO read with pending memory-stage HI/LO write.
    s = z; s.hlr_e = 1; s.hlw_m = 1; s.hlw_wb = 1;
    step(s);
    // DIV then MFLO-type held until the unit frees.
    s = z; s.st_e = 1; s.div_e = 1;
    step(s);
    s = z; s.hlr_e = 1;
    for (int i = 0; i < DIV_N + 4; i++) step(s);
    // MULT in flight, reset pulse on its second cycle.
    s = z; s.st_e = 1;
    step(s); step(z);
    s = z; s.rst = 1;
    step(s);
    s = z; s.hlr_e = 1;
    step(s); step(s);
    // Start held through a busy period is taken once free.
    s = z; s.st_e = 1;
    for (int i = 0; i < 3 * MULT_N; i++) step(s);
    for (int i = 0; i < 3000; i++) step(rnd());
    step(z);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
